// File: rtl/rv_fetch_if.sv
// rv_fetch_if: memory request/response and decoder handshake bundle.
// master = fetch unit side, slave = memory/decoder side.
interface rv_fetch_if #(
   parameter int unsigned XLEN = 32
);
   logic            req_o;
   logic [XLEN-1:0] addr_o;
   logic            gnt_i;
   logic            rvalid_i;
   logic [XLEN-1:0] rdata_i;
   logic            instr_valid_o;
   logic [XLEN-1:0] instr_o;
   logic [XLEN-1:0] instr_addr_o;
   logic            instr_ready_i;
   logic            redirect_i;
   logic [XLEN-1:0] redirect_addr_i;
   logic            err_misalign_o;

   modport master (
      output req_o, addr_o,
      input  gnt_i, rvalid_i, rdata_i,
      output instr_valid_o, instr_o, instr_addr_o,
      input  instr_ready_i, redirect_i, redirect_addr_i,
      output err_misalign_o
   );

   modport slave (
      input  req_o, addr_o,
      output gnt_i, rvalid_i, rdata_i,
      input  instr_valid_o, instr_o, instr_addr_o,
      output instr_ready_i, redirect_i, redirect_addr_i,
      input  err_misalign_o
   );
endinterface

// File: rtl/rv_fetch.sv
// rv_fetch: in-order word fetch with DEPTH-entry prefetch FIFO and flush.
// Optional misaligned-redirect flag: define RV_FETCH_ALIGN_CHK_EN.
module rv_fetch #(
   parameter int unsigned     XLEN      = 32,
   parameter logic [XLEN-1:0] BOOT_ADDR = '0,
   parameter int unsigned     DEPTH     = 2
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   rv_fetch_if.master bus
);
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CW:0] CAP = (CW+1)'(DEPTH);

   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] resp_addr_q;
   logic [CW-1:0]   out_q;
   logic [CW-1:0]   disc_q;
   logic [CW-1:0]   cnt_q;
   logic [PW-1:0]   rd_q;
   logic [PW-1:0]   wr_q;
   logic [XLEN-1:0] fa_q [DEPTH];
   logic [XLEN-1:0] fd_q [DEPTH];

   logic            issue;
   logic            drop;
   logic            push;
   logic            pop;
   logic [CW:0]     occ;
   logic [CW-1:0]   out_nxt;
   logic [XLEN-1:0] tgt;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // Buffered plus in-flight words never exceed DEPTH, so the FIFO cannot overflow.
   assign occ        = {1'b0, cnt_q} + {1'b0, out_q};
   assign bus.req_o  = rst_ni && (occ < CAP);
   assign bus.addr_o = pc_q;

   assign issue   = bus.req_o && bus.gnt_i;
   assign out_nxt = out_q + CW'(issue) - CW'(bus.rvalid_i);
   assign drop    = bus.rvalid_i && (disc_q != '0);
   assign push    = bus.rvalid_i && !drop && !bus.redirect_i;
   assign pop     = bus.instr_valid_o && bus.instr_ready_i
                    && !bus.redirect_i;
   assign tgt     = {bus.redirect_addr_i[XLEN-1:2], 2'b00};

   assign bus.instr_valid_o = (cnt_q != '0);
   assign bus.instr_o       = fd_q[rd_q];
   assign bus.instr_addr_o  = fa_q[rd_q];

   // PC, response address and in-flight/discard bookkeeping.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pc_q        <= BOOT_ADDR;
         resp_addr_q <= BOOT_ADDR;
         out_q       <= '0;
         disc_q      <= '0;
      end else if (bus.redirect_i) begin
         pc_q        <= tgt;
         resp_addr_q <= tgt;
         out_q       <= out_nxt;
         disc_q      <= out_nxt;
      end else begin
         out_q <= out_nxt;
         if (issue) pc_q <= pc_q + XLEN'(4);
         if (push) resp_addr_q <= resp_addr_q + XLEN'(4);
         if (drop) disc_q <= disc_q - CW'(1);
      end
   end

   // FIFO pointers and occupancy; a redirect empties the buffer.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
         rd_q  <= '0;
         wr_q  <= '0;
      end else if (bus.redirect_i) begin
         cnt_q <= '0;
         rd_q  <= '0;
         wr_q  <= '0;
      end else begin
         if (push) wr_q <= ptr_inc(wr_q);
         if (pop) rd_q <= ptr_inc(rd_q);
         if (push && !pop) cnt_q <= cnt_q + CW'(1);
         else if (pop && !push) cnt_q <= cnt_q - CW'(1);
      end
   end

   // FIFO storage; entries are only observed while counted valid.
   always_ff @(posedge clk_i) begin
      if (push) begin
         fa_q[wr_q] <= resp_addr_q;
         fd_q[wr_q] <= bus.rdata_i;
      end
   end

`ifdef RV_FETCH_ALIGN_CHK_EN
   logic err_q;

   // Sticky flag for a redirect target that is not word aligned.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         err_q <= 1'b0;
      end else if (bus.redirect_i && (bus.redirect_addr_i[1:0] != 2'b00)) begin
         err_q <= 1'b1;
      end
   end

   assign bus.err_misalign_o = err_q;
`else
   logic unused_lo;

   assign unused_lo          = ^bus.redirect_addr_i[1:0];
   assign bus.err_misalign_o = 1'b0;
`endif

   // A response is only legal for a previously granted request.
   always_ff @(posedge clk_i) begin
      if (rst_ni && bus.rvalid_i) begin
         assert (out_q != '0);
      end
   end
endmodule
